crossbar_slave_arbiter: RTL and testbench

Clocked per-slave arbiter and sequencer for the 2-master/2-slave crossbar. One instance sits in front of each slave port. It selects which master's request targets the slave via addr[31], breaks ties round-robin, and holds the granted transaction until the slave acks. It returns ack/rdata to the winner and aborts hung transactions on timeout.

---
 rtl/crossbar_slave_arbiter_if.sv | 31 +++
 rtl/crossbar_slave_arbiter.sv | 73 +++++++
 tb/tb_crossbar_slave_arbiter.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/crossbar_slave_arbiter_if.sv
// crossbar_slave_arbiter_if: bus between two crossbar masters, one slave port and its arbiter
interface crossbar_slave_arbiter_if;
  logic        master_1_req, master_2_req;
  logic [31:0] master_1_addr, master_2_addr;
  logic        master_1_cmd, master_2_cmd;
  logic [31:0] master_1_wdata, master_2_wdata;
  logic        master_1_ack, master_2_ack;
  logic [31:0] master_1_rdata, master_2_rdata;
  logic        slave_req;
  logic [31:0] slave_addr;
  logic        slave_cmd;
  logic [31:0] slave_wdata;
  logic        slave_ack;
  logic [31:0] slave_rdata;
  logic [1:0]  grant;
  logic        err_timeout;
  modport slave (
    input  master_1_req, master_2_req, master_1_addr, master_2_addr,
           master_1_cmd, master_2_cmd, master_1_wdata, master_2_wdata,
           slave_ack, slave_rdata,
    output master_1_ack, master_2_ack, master_1_rdata, master_2_rdata,
           slave_req, slave_addr, slave_cmd, slave_wdata, grant, err_timeout
  );
  modport master (
    output master_1_req, master_2_req, master_1_addr, master_2_addr,
           master_1_cmd, master_2_cmd, master_1_wdata, master_2_wdata,
           slave_ack, slave_rdata,
    input  master_1_ack, master_2_ack, master_1_rdata, master_2_rdata,
           slave_req, slave_addr, slave_cmd, slave_wdata, grant, err_timeout
  );
endinterface

// File: rtl/crossbar_slave_arbiter.sv
// crossbar_slave_arbiter: round-robin per-slave arbiter with transaction latch, release wait and timeout
module crossbar_slave_arbiter #(
  parameter logic        SLAVE_ID = 1'b0,
  parameter int          TIMEOUT  = 16,
  parameter logic [31:0] ERR_DATA = 32'hDEADBEEF
) (
  input logic clk,
  input logic rst,
  crossbar_slave_arbiter_if.slave bus
);
  localparam logic [1:0] IDLE = 2'd0, BUSY = 2'd1, RESP = 2'd2, REL = 2'd3;
  logic [1:0]  r_state, r_grant;
  logic        r_last, r_cmd, r_err;
  logic [7:0]  r_cnt;
  logic [31:0] r_addr, r_wdata, r_rdata1, r_rdata2;
  logic        w_e1, w_e2, w_pick2, w_tmo, w_win_req;
  logic [31:0] w_rd;
  assign w_e1 = bus.master_1_req & (bus.master_1_addr[31] == SLAVE_ID);
  assign w_e2 = bus.master_2_req & (bus.master_2_addr[31] == SLAVE_ID);
  // r_last high means M2 was served last, so M1 wins a tie
  assign w_pick2 = w_e2 & (~w_e1 | ~r_last);
  assign w_tmo = r_cnt == 8'(TIMEOUT - 1);
  assign w_win_req = r_grant[0] ? bus.master_1_req : bus.master_2_req;
  assign w_rd = bus.slave_ack ? bus.slave_rdata : ERR_DATA;
  assign bus.slave_req = r_state == BUSY;
  assign bus.slave_addr = r_addr;
  assign bus.slave_cmd = r_cmd;
  assign bus.slave_wdata = r_wdata;
  assign bus.grant = r_grant;
  assign bus.err_timeout = r_err;
  assign bus.master_1_ack = (r_state == RESP) & r_grant[0];
  assign bus.master_2_ack = (r_state == RESP) & r_grant[1];
  assign bus.master_1_rdata = r_rdata1;
  assign bus.master_2_rdata = r_rdata2;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_grant <= 2'b00;
      r_last <= 1'b1;
      r_cnt <= 8'd0;
      r_cmd <= 1'b0;
      r_addr <= 32'd0;
      r_wdata <= 32'd0;
      r_rdata1 <= 32'd0;
      r_rdata2 <= 32'd0;
      r_err <= 1'b0;
    end else begin
      r_err <= 1'b0;
      case (r_state)
        IDLE: if (w_e1 | w_e2) begin
          r_grant <= w_pick2 ? 2'b10 : 2'b01;
          r_last <= w_pick2;
          r_addr <= w_pick2 ? bus.master_2_addr : bus.master_1_addr;
          r_cmd <= w_pick2 ? bus.master_2_cmd : bus.master_1_cmd;
          r_wdata <= w_pick2 ? bus.master_2_wdata : bus.master_1_wdata;
          r_cnt <= 8'd0;
          r_state <= BUSY;
        end
        BUSY: if (bus.slave_ack | w_tmo) begin
          if (!r_cmd && r_grant[0]) r_rdata1 <= w_rd;
          if (!r_cmd && r_grant[1]) r_rdata2 <= w_rd;
          r_err <= ~bus.slave_ack;
          r_state <= RESP;
        end else r_cnt <= r_cnt + 8'd1;
        RESP: r_state <= REL;
        default: if (!w_win_req) begin
          r_grant <= 2'b00;
          r_state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_crossbar_slave_arbiter.sv
// tb_crossbar_slave_arbiter: directed checks of arbitration, round-robin, timeout, release and reset
module tb_crossbar_slave_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int total = 0;
  int bad = 0;
  int n;
  crossbar_slave_arbiter_if bus();
  crossbar_slave_arbiter dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  initial begin
    bus.master_1_req = 0; bus.master_2_req = 0;
    bus.master_1_addr = 0; bus.master_2_addr = 0;
    bus.master_1_cmd = 0; bus.master_2_cmd = 0;
    bus.master_1_wdata = 0; bus.master_2_wdata = 0;
    bus.slave_ack = 0; bus.slave_rdata = 0;
    tick(); tick();
    rst = 0;
    chk("rst_grant", 32'(bus.grant), 32'd0);
    chk("rst_sreq", 32'(bus.slave_req), 32'd0);
    chk("rst_saddr", bus.slave_addr, 32'd0);
    chk("rst_scmd", 32'(bus.slave_cmd), 32'd0);
    chk("rst_swdata", bus.slave_wdata, 32'd0);
    chk("rst_ack", 32'({bus.master_1_ack, bus.master_2_ack, bus.err_timeout}), 32'd0);
    chk("rst_rdata1", bus.master_1_rdata, 32'd0);
    chk("rst_rdata2", bus.master_2_rdata, 32'd0);
    // M1 write, slave acks two cycles after slave_req rises
    bus.master_1_req = 1; bus.master_1_cmd = 1;
    bus.master_1_addr = 32'h7fffffff; bus.master_1_wdata = 32'h11111111;
    tick();
    chk("w1_sreq", 32'(bus.slave_req), 32'd1);
    chk("w1_grant", 32'(bus.grant), 32'd1);
    chk("w1_saddr", bus.slave_addr, 32'h7fffffff);
    chk("w1_swdata", bus.slave_wdata, 32'h11111111);
    chk("w1_scmd", 32'(bus.slave_cmd), 32'd1);
    chk("w1_noack", 32'(bus.master_1_ack), 32'd0);
    tick();
    bus.slave_ack = 1;
    tick();
    bus.slave_ack = 0;
    chk("w1_ack", 32'(bus.master_1_ack), 32'd1);
    chk("w1_ack2", 32'(bus.master_2_ack), 32'd0);
    chk("w1_sreq_off", 32'(bus.slave_req), 32'd0);
    chk("w1_rdata", bus.master_1_rdata, 32'd0);
    chk("w1_err", 32'(bus.err_timeout), 32'd0);
    bus.master_1_req = 0;
    tick();
    chk("w1_ack_pulse", 32'(bus.master_1_ack), 32'd0);
    chk("w1_rel_grant", 32'(bus.grant), 32'd1);
    tick();
    chk("w1_idle_grant", 32'(bus.grant), 32'd0);
    // M2 read
    bus.master_2_req = 1; bus.master_2_cmd = 0; bus.master_2_addr = 32'h7fffffff;
    tick();
    chk("r2_grant", 32'(bus.grant), 32'd2);
    chk("r2_scmd", 32'(bus.slave_cmd), 32'd0);
    bus.slave_rdata = 32'h10000002; bus.slave_ack = 1;
    tick();
    bus.slave_ack = 0;
    chk("r2_ack", 32'(bus.master_2_ack), 32'd1);
    chk("r2_rdata", bus.master_2_rdata, 32'h10000002);
    chk("r2_ack1", 32'(bus.master_1_ack), 32'd0);
    chk("r2_rdata1", bus.master_1_rdata, 32'd0);
    bus.master_2_req = 0;
    tick(); tick();
    chk("r2_idle", 32'(bus.grant), 32'd0);
    // addr[31] selects the other slave: never served here
    bus.master_2_req = 1; bus.master_2_addr = 32'hffffffff;
    n = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (bus.slave_req || bus.grant != 2'b00) n++;
    end
    chk("decode_other", 32'(n), 32'd0);
    bus.master_2_req = 0;
    // tie after M2 served last: M1 first, then M2
    bus.master_1_req = 1; bus.master_1_cmd = 1; bus.master_1_addr = 32'h1fffffff; bus.master_1_wdata = 32'haaaa0001;
    bus.master_2_req = 1; bus.master_2_cmd = 1; bus.master_2_addr = 32'h7fffffff; bus.master_2_wdata = 32'hbbbb0002;
    tick();
    chk("tie1_grant", 32'(bus.grant), 32'd1);
    chk("tie1_saddr", bus.slave_addr, 32'h1fffffff);
    bus.slave_ack = 1;
    tick();
    bus.slave_ack = 0;
    chk("tie1_ack", 32'(bus.master_1_ack), 32'd1);
    bus.master_1_req = 0;
    tick(); tick();
    chk("tie1_idle", 32'(bus.grant), 32'd0);
    tick();
    chk("tie2_grant", 32'(bus.grant), 32'd2);
    chk("tie2_swdata", bus.slave_wdata, 32'hbbbb0002);
    bus.slave_ack = 1;
    tick();
    bus.slave_ack = 0;
    chk("tie2_ack", 32'(bus.master_2_ack), 32'd1);
    chk("tie2_rdata2", bus.master_2_rdata, 32'h10000002);
    bus.master_2_req = 0;
    tick(); tick();
    bus.master_1_req = 1; bus.master_2_req = 1;
    tick();
    chk("tie3_grant", 32'(bus.grant), 32'd1);
    bus.slave_ack = 1;
    tick();
    bus.slave_ack = 0;
    bus.master_1_req = 0; bus.master_2_req = 0;
    tick(); tick();
    chk("tie3_idle", 32'(bus.grant), 32'd0);
    // timeout on M1 read
    bus.master_1_req = 1; bus.master_1_cmd = 0; bus.master_1_addr = 32'h00000000;
    tick();
    n = 0;
    for (int i = 0; i < 40 && bus.slave_req; i++) begin
      n++;
      tick();
    end
    chk("tmo_len", 32'(n), 32'd16);
    chk("tmo_ack", 32'(bus.master_1_ack), 32'd1);
    chk("tmo_err", 32'(bus.err_timeout), 32'd1);
    chk("tmo_rdata", bus.master_1_rdata, 32'hdeadbeef);
    chk("tmo_rdata2", bus.master_2_rdata, 32'h10000002);
    bus.master_1_req = 0;
    tick();
    chk("tmo_err_pulse", 32'(bus.err_timeout), 32'd0);
    tick();
    // held request served only once
    bus.master_1_req = 1; bus.master_1_cmd = 1; bus.master_1_addr = 32'h00000010;
    tick();
    bus.slave_ack = 1;
    tick();
    bus.slave_ack = 0;
    chk("hold_ack", 32'(bus.master_1_ack), 32'd1);
    n = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (bus.slave_req || bus.master_1_ack) n++;
    end
    chk("hold_once", 32'(n), 32'd0);
    chk("hold_grant", 32'(bus.grant), 32'd1);
    bus.master_1_req = 0;
    tick();
    chk("hold_release", 32'(bus.grant), 32'd0);
    // reset during BUSY drops the transaction
    bus.master_1_req = 1; bus.master_1_cmd = 0;
    tick();
    chk("rb_sreq", 32'(bus.slave_req), 32'd1);
    rst = 1;
    tick();
    rst = 0;
    chk("rb_sreq_off", 32'(bus.slave_req), 32'd0);
    chk("rb_grant", 32'(bus.grant), 32'd0);
    chk("rb_noack", 32'({bus.master_1_ack, bus.err_timeout}), 32'd0);
    chk("rb_saddr", bus.slave_addr, 32'd0);
    tick();
    chk("rb_regrant", 32'(bus.grant), 32'd1);
    bus.slave_rdata = 32'h12345678; bus.slave_ack = 1;
    tick();
    bus.slave_ack = 0;
    chk("rb_ack", 32'(bus.master_1_ack), 32'd1);
    chk("rb_rdata", bus.master_1_rdata, 32'h12345678);
    bus.master_1_req = 0;
    tick(); tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
